mem_rd_streamer: RTL and testbench
==================================

Name: mem_rd_streamer

Overview:
- Downstream read stage for the dual-port block memory. That memory returns mem[addr_out] on rd_data one clock after addr_out is presented, and it reads every cycle.
- On a start pulse, this block reads len consecutive words beginning at base_addr, wrapping at 2^ADDR_WIDTH.
- It presents the words as a valid/ready stream with a last flag, without loss or duplication under arbitrary backpressure.
- A 2-entry output buffer absorbs the one-cycle memory latency so the stream runs at full rate when m_ready is held high.

Parameters:
- BIT_WIDTH, 8, data word width; matches the memory.
- ADDR_WIDTH, 4, memory address width; depth is 2^ADDR_WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first read address; sampled with start.
- len  input  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; sampled with start.
- rd_en  output  1  read-issue strobe to memory.
- addr_out  output  ADDR_WIDTH  memory read address.
- rd_data  input  BIT_WIDTH  memory read data; valid the cycle after an issue.
- m_data  output  BIT_WIDTH  stream data.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready.
- m_last  output  1  marks the final word of a transfer.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; buffer emptied; all counters cleared.
  - rd_en=0, addr_out=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0.
  - Reset mid-transfer abandons the transfer; no done is generated.
- FSM states:
  - IDLE: start=1 and len!=0 -> RUN; capture base_addr and len; issued=0; sent=0.
  - IDLE: start=1 and len=0 -> DONE; no reads issued.
  - RUN: once issued==len, stay in RUN until sent==len, then go to DONE. The last accepted beat (m_valid & m_ready & m_last) causes this transition.
  - DONE: done=1 for exactly one cycle -> IDLE.
  - start outside IDLE is ignored.
- Issue rule (combinational, RUN only):
  - rd_en = (issued<len) && (count + inflight - pop < 2).
  - count: buffer occupancy. inflight: rd_en registered one cycle. pop: m_valid & m_ready.
  - addr_out = (base + issued) mod 2^ADDR_WIDTH; addr_out=0 when rd_en=0.
  - issued increments on each rd_en.
- Capture:
  - When inflight=1, rd_data is written into the buffer tail at that clock edge.
  - The tail word's last flag = (its issue index == len-1).
  - The issue rule guarantees the buffer never overflows; an overflow is a design error.
- Output:
  - m_valid = (count!=0). m_data and m_last come from the buffer head.
  - The head is held stable while m_valid=1 and m_ready=0.
  - Simultaneous push and pop with count=1 leaves count=1 with the new word at the head.
- Latency: start in cycle C gives rd_en in C+1, rd_data in C+2, and m_valid in C+3 (with m_ready=1).
- Throughput: with m_ready held high, one word per cycle; len words complete by C+2+len; done fires the cycle after the last beat.
- busy: high in RUN and DONE, low in IDLE.
- len = 2^ADDR_WIDTH: every address is read exactly once, starting from base and wrapping.

Test Plan:
- Reset, then start with base=3, len=4, m_ready=1 -> addr_out 3,4,5,6 in C+1..C+4; m_data = mem[3..6] in C+3..C+6; m_last only in C+6; done in C+7.
- base=14, len=4, ADDR_WIDTH=4 -> addresses 14,15,0,1; data order preserved.
- len=5, m_ready toggling 1,0,0,1,0,1... -> exactly 5 beats in address order, no duplicates; m_data stable while stalled; rd_en never issued when count+inflight-pop reaches 2.
- start with len=0 -> no rd_en; done in C+1; busy high only in C+1.
- start pulsed again during RUN -> ignored; byte count and done unaffected.
- rst_n asserted mid-transfer (after 2 of 6 beats) -> all outputs 0 immediately; no done; a fresh start afterwards works normally.

Source files
------------

// File: rtl/mem_rd_streamer_if.sv
// Output stream of the memory read streamer: data, valid/ready handshake and last-word flag.
interface mem_rd_streamer_if #(
  parameter int BIT_WIDTH = 8
);
  logic [BIT_WIDTH-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/mem_rd_streamer.sv
// Streams len words from a 1-cycle-latency block memory through a 2-entry skid buffer.
// States: IDLE wait for start | RUN issue reads and stream | DONE one-cycle done pulse.
module mem_rd_streamer #(
  parameter int BIT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] addr_out_o,
  input  logic [BIT_WIDTH-1:0]  rd_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  mem_rd_streamer_if.master     m_if
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH:0] ONE = 1;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic [ADDR_WIDTH:0]     issued_q, issued_d;
  logic                    inflight_q, inflight_last_q;
  logic [BIT_WIDTH-1:0]    head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic                    head_last_q, head_last_d, tail_last_q, tail_last_d;
  logic [1:0]              count_q, count_d;
  logic                    rd_en, done, pop, push;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [2:0]              occ;

  assign pop  = m_if.m_valid & m_if.m_ready;
  assign push = inflight_q;
  assign occ  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q;
    rd_en    = 1'b0;
    addr     = '0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          base_d   = base_addr_i;
          len_d    = len_i;
          issued_d = '0;
          state_d  = (len_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if ((issued_q < len_q) && (occ < 3'd2)) begin
          rd_en    = 1'b1;
          addr     = base_q + issued_q[ADDR_WIDTH-1:0];
          issued_d = issued_q + ONE;
        end
        if (pop && head_last_q) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Incoming word goes to the head when it would otherwise be the only occupant.
  always_comb begin
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;
    count_d     = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_data_d = rd_data_i;
          head_last_d = inflight_last_q;
        end else begin
          tail_data_d = rd_data_i;
          tail_last_d = inflight_last_q;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_data_d = tail_data_q;
        head_last_d = tail_last_q;
        count_d     = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_data_d = rd_data_i;
          head_last_d = inflight_last_q;
        end else begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
          tail_data_d = rd_data_i;
          tail_last_d = inflight_last_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      base_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      head_data_q     <= '0;
      head_last_q     <= 1'b0;
      tail_data_q     <= '0;
      tail_last_q     <= 1'b0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en && (issued_q == len_q - ONE);
      head_data_q     <= head_data_d;
      head_last_q     <= head_last_d;
      tail_data_q     <= tail_data_d;
      tail_last_q     <= tail_last_d;
      count_q         <= count_d;
    end
  end

  assign rd_en_o      = rd_en;
  assign addr_out_o   = addr;
  assign done_o       = done;
  assign busy_o       = (state_q != S_IDLE);
  assign m_if.m_valid = (count_q != 2'd0);
  assign m_if.m_data  = head_data_q;
  assign m_if.m_last  = head_last_q & (count_q != 2'd0);

endmodule

// File: tb/tb_mem_rd_streamer.sv
// Scoreboard bench: expected beats/addresses queued at start, checked by an independent monitor.
module tb_mem_rd_streamer;
  localparam int BW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          rd_en;
  logic [AW-1:0] addr_out;
  logic [BW-1:0] rd_data = '0;
  logic          busy, done;

  mem_rd_streamer_if #(.BIT_WIDTH(BW)) m_if ();

  mem_rd_streamer #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .base_addr_i (base_addr),
    .len_i       (len),
    .rd_en_o     (rd_en),
    .addr_out_o  (addr_out),
    .rd_data_i   (rd_data),
    .busy_o      (busy),
    .done_o      (done),
    .m_if        (m_if.master)
  );

  always #5 clk = ~clk;

  logic [BW-1:0] mem [DEPTH];
  always @(posedge clk) rd_data <= mem[addr_out];

  typedef struct {
    logic [BW-1:0] d;
    logic          l;
  } beat_t;

  beat_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  bit            pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Monitor: in-order beat/address scoreboard, stall stability, outstanding-read window.
  int            iss_total = 0, pop_total = 0;
  bit            stall_prev = 0;
  logic [BW-1:0] prev_d;
  logic          prev_l;

  always @(negedge clk) begin
    bit    pop;
    beat_t e;
    if (!rst_n) begin
      iss_total  = 0;
      pop_total  = 0;
      stall_prev = 0;
    end else begin
      pop = m_if.m_valid && m_if.m_ready;
      if (rd_en) begin
        check("rd_window", 32'((iss_total - pop_total - int'(pop)) <= 1), 32'd1);
        if (addr_q.size() == 0) flag_fail("addr_unexpected_read");
        else check("addr_out", 32'(addr_out), 32'(addr_q.pop_front()));
        iss_total++;
      end else begin
        check("addr_idle_zero", 32'(addr_out), 32'd0);
      end
      if (stall_prev) begin
        check("stall_valid", 32'(m_if.m_valid), 32'd1);
        check("stall_data", 32'(m_if.m_data), 32'(prev_d));
        check("stall_last", 32'(m_if.m_last), 32'(prev_l));
      end
      if (pop) begin
        if (exp_q.size() == 0) flag_fail("beat_unexpected");
        else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(m_if.m_data), 32'(e.d));
          check("beat_last", 32'(m_if.m_last), 32'(e.l));
        end
        pop_total++;
      end
      stall_prev = m_if.m_valid && !m_if.m_ready;
      prev_d     = m_if.m_data;
      prev_l     = m_if.m_last;
    end
  end

  task automatic push_expect(input int b, input int l);
    beat_t e;
    for (int i = 0; i < l; i++) begin
      e.d = mem[(b + i) % DEPTH];
      e.l = (i == l - 1);
      exp_q.push_back(e);
      addr_q.push_back(AW'((b + i) % DEPTH));
    end
  endtask

  // mode 0: ready held high with cycle-exact checks; 1: fixed toggle pattern; 2: random ready
  task automatic run_xfer(input int b, input int l, input int mode, input bit restart);
    bit got_done = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = AW'(b);
    len       = (AW+1)'(l);
    push_expect(b, l);
    for (int k = 1; k <= 400 && !got_done; k++) begin
      @(posedge clk); #1;
      start = restart && (k == 2);
      if (start) begin
        base_addr = AW'($urandom_range(0, DEPTH - 1));
        len       = (AW+1)'($urandom_range(1, DEPTH));
      end
      case (mode)
        0:       m_if.m_ready = 1'b1;
        1:       m_if.m_ready = pat[k % 6];
        default: m_if.m_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (mode == 0) begin
        check("t_rd_en", 32'(rd_en), 32'(k <= l));
        check("t_m_valid", 32'(m_if.m_valid), 32'(k >= 3 && k <= l + 2));
        check("t_done", 32'(done), 32'((l == 0) ? (k == 1) : (k == l + 3)));
        check("t_busy", 32'(busy), 32'd1);
      end
      if (done) got_done = 1;
    end
    if (!got_done) flag_fail("done_timeout");
    check("beats_drained", 32'(exp_q.size()), 32'd0);
    check("addrs_drained", 32'(addr_q.size()), 32'd0);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check({tag, "_addr"}, 32'(addr_out), 32'd0);
    check({tag, "_valid"}, 32'(m_if.m_valid), 32'd0);
    check({tag, "_last"}, 32'(m_if.m_last), 32'd0);
    check({tag, "_data"}, 32'(m_if.m_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic reset_mid_xfer();
    int b = $urandom_range(0, DEPTH - 1);
    int pops = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = AW'(b);
    len       = 6;
    push_expect(b, 6);
    for (int k = 0; k < 50 && pops < 2; k++) begin
      @(posedge clk); #1;
      start        = 1'b0;
      m_if.m_ready = 1'b1;
      @(negedge clk);
      if (m_if.m_valid && m_if.m_ready) pops++;
    end
    if (pops < 2) flag_fail("reset_wait_timeout");
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    exp_q.delete();
    addr_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = BW'($urandom);
    m_if.m_ready = 1'b1;
    #2 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_xfer(3, 4, 0, 1'b0);
    run_xfer(14, 4, 0, 1'b0);
    run_xfer($urandom_range(0, DEPTH - 1), 5, 1, 1'b0);
    run_xfer($urandom_range(0, DEPTH - 1), 0, 0, 1'b0);
    run_xfer($urandom_range(0, DEPTH - 1), 4, 0, 1'b1);
    run_xfer($urandom_range(0, DEPTH - 1), DEPTH, 0, 1'b0);
    run_xfer($urandom_range(0, DEPTH - 1), DEPTH, 2, 1'b0);
    reset_mid_xfer();
    run_xfer($urandom_range(0, DEPTH - 1), 6, 0, 1'b0);
    for (int t = 0; t < 12; t++)
      run_xfer($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH), $urandom_range(0, 2), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
